// File: rtl/uart_sdram_bridge_if.sv
// UART byte channel plus SDRAM FIFO user ports seen by the host command bridge.
// The bridge takes the master side; the UART/SDRAM environment takes the slave side.
interface uart_sdram_bridge_if;
   logic        rx_done;
   logic [7:0]  rx_data;
   logic        tx_busy;
   logic        tx_en;
   logic [7:0]  tx_data;
   logic        wr_en;
   logic [15:0] wr_data;
   logic        rd_en;
   logic [15:0] rd_data;

   modport master (
      input  rx_done, rx_data, tx_busy, rd_data,
      output tx_en, tx_data, wr_en, wr_data, rd_en
   );

   modport slave (
      output rx_done, rx_data, tx_busy, rd_data,
      input  tx_en, tx_data, wr_en, wr_data, rd_en
   );
endinterface

// File: rtl/uart_sdram_bridge.sv
// Host command bridge: parses 'W'/'R' frames from UART bytes, pushes words into the SDRAM
// write FIFO and streams words popped from the read FIFO back out as byte pairs.
module uart_sdram_bridge #(
   parameter int unsigned TIMEOUT_CLKS = 5_000_000,
   parameter int unsigned RD_LAT       = 1,
   parameter logic [7:0]  CMD_WR       = 8'h57,
   parameter logic [7:0]  CMD_RD       = 8'h52
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic                init_done,
   uart_sdram_bridge_if.master bus,
   output logic                busy,
   output logic                frame_err,
   output logic [15:0]         word_cnt
);
   localparam int unsigned     TmrW    = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CLKS - 1);
   localparam logic [1:0]      LatLast = 2'(RD_LAT - 1);

   typedef enum logic [3:0] {
      StIdle, StWLen, StWLo, StWHi, StRLen, StRReq, StRWait, StTxLo, StTxHi
   } state_e;

   state_e          state_q, state_d;
   logic [TmrW-1:0] tmr_q;
   logic [8:0]      rem_q;
   logic [7:0]      lo_q;
   logic [15:0]     hold_q;
   logic [1:0]      lat_q;
   logic [1:0]      guard_q;
   logic            wr_en_q;
   logic [15:0]     wr_data_q;
   logic            tx_en_q;
   logic [7:0]      tx_data_q;
   logic            frame_err_q;
   logic [15:0]     word_cnt_q;

   logic rx_ok, tmr_active, timeout, push, cap, fire, last;

   assign rx_ok = init_done & bus.rx_done;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state_q <= StIdle;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (rx_ok && bus.rx_data == CMD_WR)      state_d = StWLen;
            else if (rx_ok && bus.rx_data == CMD_RD) state_d = StRLen;
         end
         StWLen: begin
            if (rx_ok)        state_d = StWLo;
            else if (timeout) state_d = StIdle;
         end
         StWLo: begin
            if (rx_ok)        state_d = StWHi;
            else if (timeout) state_d = StIdle;
         end
         StWHi: begin
            if (rx_ok)        state_d = last ? StIdle : StWLo;
            else if (timeout) state_d = StIdle;
         end
         StRLen: begin
            if (rx_ok)        state_d = StRReq;
            else if (timeout) state_d = StIdle;
         end
         StRReq:  if (bus.rd_en) state_d = StRWait;
         StRWait: if (cap)       state_d = StTxLo;
         StTxLo:  if (fire)      state_d = StTxHi;
         StTxHi:  if (fire)      state_d = last ? StIdle : StRReq;
         default:                state_d = StIdle;
      endcase
   end

   always_comb begin
      busy       = (state_q != StIdle);
      tmr_active = state_q inside {StWLen, StWLo, StWHi, StRLen};
      // A byte landing in the expiry cycle still counts, so rx_ok masks the timeout.
      timeout    = tmr_active && init_done && !rx_ok && (tmr_q == TmrLast);
      push       = (state_q == StWHi) && rx_ok;
      bus.rd_en  = (state_q == StRReq) && init_done;
      cap        = (state_q == StRWait) && (lat_q == LatLast);
      fire       = (state_q inside {StTxLo, StTxHi}) && init_done && !bus.tx_busy &&
                   (guard_q == 2'd0);
      last       = (rem_q <= 9'd1);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tmr_q       <= '0;
         rem_q       <= '0;
         lo_q        <= '0;
         hold_q      <= '0;
         lat_q       <= '0;
         guard_q     <= '0;
         wr_en_q     <= 1'b0;
         wr_data_q   <= '0;
         tx_en_q     <= 1'b0;
         tx_data_q   <= '0;
         frame_err_q <= 1'b0;
         word_cnt_q  <= '0;
      end else begin
         if (!tmr_active || rx_ok) tmr_q <= '0;
         else if (init_done)       tmr_q <= tmr_q + 1'b1;

         // A length byte of zero encodes 256 words.
         if (rx_ok && (state_q == StWLen || state_q == StRLen)) begin
            rem_q <= {bus.rx_data == 8'd0, bus.rx_data};
         end else if (push || (fire && state_q == StTxHi)) begin
            rem_q <= rem_q - 9'd1;
         end

         if (rx_ok && state_q == StWLo) lo_q <= bus.rx_data;

         wr_en_q <= push;
         if (push) begin
            wr_data_q  <= {bus.rx_data, lo_q};
            word_cnt_q <= word_cnt_q + 16'd1;
         end

         lat_q <= (state_q == StRWait) ? lat_q + 2'd1 : 2'd0;
         if (cap) hold_q <= bus.rd_data;

         tx_en_q <= fire;
         if (fire) tx_data_q <= (state_q == StTxLo) ? hold_q[7:0] : hold_q[15:8];

         // tx_en leaves one cycle after fire; 3 masks it plus the two busy-rise cycles.
         if (fire)                  guard_q <= 2'd3;
         else if (guard_q != 2'd0)  guard_q <= guard_q - 2'd1;

         frame_err_q <= timeout;
      end
   end

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_data = wr_data_q;
   assign bus.tx_en   = tx_en_q;
   assign bus.tx_data = tx_data_q;
   assign frame_err   = frame_err_q;
   assign word_cnt    = word_cnt_q;
endmodule

// File: doc/uart_sdram_bridge.md
Name: uart_sdram_bridge

Overview:
- Command bridge between the byte-wide UART receiver/transmitter and the FIFO-style user ports of the SDRAM controller.
- Parses host frames from received bytes:
  - 'W' frames pack byte pairs into 16-bit words and push them into the SDRAM write FIFO.
  - 'R' frames pop words from the SDRAM read FIFO and stream them back as byte pairs.
- Replaces key/LED test logic as the host-driven SDRAM exerciser.

Parameters:
- TIMEOUT_CLKS, 5_000_000, inter-byte timeout inside a frame (100 ms at 50 MHz).
- RD_LAT, 1, cycles from rd_en to valid rd_data; legal range 1..3.
- CMD_WR, 8'h57, write command byte ('W').
- CMD_RD, 8'h52, read command byte ('R').

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- init_done  in  1  SDRAM initialisation complete.
- rx_done  in  1  one-cycle strobe, rx_data valid.
- rx_data  in  8  received byte.
- tx_busy  in  1  transmitter shifting a byte.
- tx_en  out  1  one-cycle send strobe.
- tx_data  out  8  byte to send; stable while tx_busy high.
- wr_en  out  1  write FIFO push strobe.
- wr_data  out  16  write word.
- rd_en  out  1  read FIFO pop strobe.
- rd_data  in  16  read word, valid RD_LAT cycles after rd_en.
- busy  out  1  high in any state except IDLE.
- frame_err  out  1  one-cycle pulse on timeout abort.
- word_cnt  out  16  total words written since reset, wraps at 65535->0.

Behaviour:
- Reset (async, sys_rst_n low): state IDLE; all outputs 0; internal counters 0. Release is synchronous to the next sys_clk edge.
- init_done low: rx_done strobes are ignored in every state; the state machine holds.
- Frame formats:
  - Write: CMD_WR, C, then 2*C data bytes, low byte first.
  - Read: CMD_RD, C.
  - C = 0 means 256 words. Internal word counter is 9 bits.
- States:
  - IDLE: on rx_done with CMD_WR -> W_LEN; with CMD_RD -> R_LEN. Any other byte is discarded; stay IDLE.
  - W_LEN: on rx_done, load remaining count = (rx_data==0 ? 256 : rx_data) -> W_LO.
  - W_LO: on rx_done, latch low byte -> W_HI.
  - W_HI: on rx_done, in the next cycle:
    - wr_en=1 for exactly one cycle, wr_data={rx_data, low};
    - word_cnt+1; remaining-1;
    - -> W_LO if remaining was >1, else IDLE.
    - wr_data holds its value after the strobe.
  - R_LEN: on rx_done, load count -> R_REQ.
  - R_REQ: rd_en=1 for one cycle -> R_WAIT.
  - R_WAIT: wait RD_LAT cycles after rd_en, capture rd_data into a 16-bit hold register -> TX_LO.
  - TX_LO: when tx_busy=0 and guard expired, tx_en=1 one cycle with tx_data=hold[7:0] -> TX_HI.
  - TX_HI: same rule, tx_data=hold[15:8]; remaining-1; -> R_REQ if remaining was >1, else IDLE.
- Tx guard: after each tx_en, tx_busy is ignored for 2 cycles, covering the transmitter's busy-rise latency. Never issue tx_en while tx_busy=1.
- Only one rd_en is outstanding at a time. Exactly C rd_en pulses and 2*C tx_en pulses per read frame.
- Bytes arriving during R_REQ/R_WAIT/TX_*: discarded; no queuing.
- Timeout:
  - Applies in W_LEN, W_LO, W_HI and R_LEN.
  - Idle counter resets on every rx_done; reaching TIMEOUT_CLKS -> IDLE plus frame_err pulse.
  - A partially received word is dropped; no wr_en is issued for it.
  - Read-streaming states never time out.
- Simultaneous rx_done and timeout expiry in the same cycle: rx_done wins.
- wr_en and rd_en are never high in the same cycle.
- busy rises the cycle after the command byte and falls the cycle IDLE is re-entered.

Test Plan:
- Reset mid-stream: after the 3rd byte of 57 02 34 12 78 56 assert sys_rst_n=0 -> all outputs 0 immediately; the next 34 12 bytes produce no wr_en.
- Write frame: init_done=1, send 57 02 34 12 78 56 -> wr_en pulses twice with wr_data 1234 then 5678; word_cnt=2; busy low after the last pulse.
- Read frame with RD_LAT=1: send 52 01, model returns ABCD one cycle after rd_en -> single rd_en; tx_en twice with tx_data CD then AB; no tx_en while tx_busy=1.
- Count zero: send 52 00 -> exactly 256 rd_en and 512 tx_en, then IDLE.
- Timeout: send 57 01 34, then silence TIMEOUT_CLKS cycles -> frame_err one pulse, no wr_en, state IDLE. Then 57 01 CD AB -> wr_data ABCD.
- Gating and noise: init_done=0, send 57 01 11 22 -> no wr_en, busy=0. With init_done=1, send stray 00 FF before 52 01 -> stray bytes ignored, read proceeds normally.
